guess_scoreboard: RTL and testbench

- Downstream consumer of the guess FSM.
- Counts win and lose events from the FSM's win/lose outputs in two independent 2-digit BCD counters (00–99).
- Time-multiplexes both scores onto a 4-digit common-anode seven-segment display.
- Sits between the guess FSM and the board display pins.

---
 rtl/guess_scoreboard.sv | 110 +++++++++++
 tb/tb_guess_scoreboard.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/guess_scoreboard.sv
// rtl/guess_scoreboard.sv - win/lose BCD scoreboard driving a 4-digit multiplexed 7-seg display
// Optional macro SCORE_SATURATE_EN: counters saturate at 99 instead of wrapping to 00.
module guess_scoreboard #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       win,
  input  logic       lose,
  input  logic       clr,
  output logic [7:0] win_cnt,
  output logic [7:0] lose_cnt,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REFRESH_DIV - 1);

  logic             win_q;
  logic             lose_q;
  logic             win_ev;
  logic             lose_ev;
  logic [CNT_W-1:0] ref_cnt;
  logic [1:0]       idx;
  logic [3:0]       digit;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
`ifdef SCORE_SATURATE_EN
    if (v == 8'h99) return v;
`endif
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd9) return 8'h00;
      return {v[7:4] + 4'd1, 4'd0};
    end
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] seg_dec(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [3:0] an_dec(input logic [1:0] i);
    case (i)
      2'd0:    return 4'b1110;
      2'd1:    return 4'b1101;
      2'd2:    return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  assign win_ev  = win & ~win_q;
  assign lose_ev = lose & ~lose_q;

  // Digit order: lose ones, lose tens, win ones, win tens.
  always_comb begin
    digit = 4'd0;
    case (idx)
      2'd0:    digit = lose_cnt[3:0];
      2'd1:    digit = lose_cnt[7:4];
      2'd2:    digit = win_cnt[3:0];
      default: digit = win_cnt[7:4];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
      win_cnt  <= 8'h00;
      lose_cnt <= 8'h00;
      ref_cnt  <= '0;
      idx      <= 2'd0;
      an       <= 4'b1111;
      seg      <= 7'b1111111;
    end else begin
      // Edge registers track the inputs even during clr so held levels are not recounted.
      win_q  <= win;
      lose_q <= lose;
      if (clr) begin
        win_cnt  <= 8'h00;
        lose_cnt <= 8'h00;
      end else begin
        if (win_ev)  win_cnt  <= bcd_inc(win_cnt);
        if (lose_ev) lose_cnt <= bcd_inc(lose_cnt);
      end
      if (ref_cnt == REF_LAST) begin
        ref_cnt <= '0;
        idx     <= idx + 2'd1;
      end else begin
        ref_cnt <= ref_cnt + CNT_W'(1);
      end
      an  <= an_dec(idx);
      seg <= seg_dec(digit);
    end
  end

endmodule

// File: tb/tb_guess_scoreboard.sv
// tb/tb_guess_scoreboard.sv - scoreboard bench for guess_scoreboard with REFRESH_DIV = 4
module tb_guess_scoreboard;

`ifdef SCORE_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       win = 1'b0;
  logic       lose = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] win_cnt;
  logic [7:0] lose_cnt;
  logic [3:0] an;
  logic [6:0] seg;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] cnt_q[$];
  logic [10:0] scan_q[$];
  int          mw = 0;
  int          ml = 0;
  bit          scan_en = 1'b0;
  bit          scan_sync = 1'b0;
  bit          scan_done = 1'b0;
  int          scan_wait = 0;
  logic [15:0] prev_cnt = 16'h0000;
  logic [3:0]  prev_an = 4'b1111;

  guess_scoreboard #(.REFRESH_DIV(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .win(win), .lose(lose), .clr(clr),
    .win_cnt(win_cnt), .lose_cnt(lose_cnt), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every visible change of the score pair consumes one expected entry.
  always @(negedge clk) begin
    logic [15:0] cur;
    if (rst) begin
      prev_cnt = {win_cnt, lose_cnt};
      prev_an  = an;
    end else begin
      cur = {win_cnt, lose_cnt};
      if (cur !== prev_cnt) begin
        if (cnt_q.size() == 0) check("unexpected_count_change", cur, prev_cnt);
        else check("count", cur, cnt_q.pop_front());
        prev_cnt = cur;
      end
      if (scan_en && !scan_sync) begin
        scan_wait++;
        if (an == 4'b1110 && prev_an != 4'b1110) scan_sync = 1'b1;
        else if (scan_wait > 64) begin
          check("scan_sync_timeout", an, 4'b1110);
          scan_en   = 1'b0;
          scan_done = 1'b1;
        end
      end
      if (scan_en && scan_sync) begin
        check("scan", {an, seg}, scan_q.pop_front());
        if (scan_q.size() == 0) begin
          scan_en   = 1'b0;
          scan_done = 1'b1;
        end
      end
      prev_an = an;
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic push_cnt;
    cnt_q.push_back({to_bcd(mw), to_bcd(ml)});
  endtask

  task automatic pulse(input bit w, input bit l);
    int nw;
    int nl;
    nw = mw;
    nl = ml;
    if (w) nw = SAT ? ((mw == 99) ? 99 : mw + 1) : (mw + 1) % 100;
    if (l) nl = SAT ? ((ml == 99) ? 99 : ml + 1) : (ml + 1) % 100;
    if (nw != mw || nl != ml) begin
      mw = nw;
      ml = nl;
      push_cnt();
    end
    win  = w;
    lose = l;
    tick();
    win  = 1'b0;
    lose = 1'b0;
    tick();
  endtask

  task automatic do_clr;
    if (mw != 0 || ml != 0) begin
      mw = 0;
      ml = 0;
      push_cnt();
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
  endtask

  task automatic wait_an(input logic [3:0] target, input logic [6:0] exp_seg, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (an == target) found = 1'b1;
    end
    check({name, "_an"}, an, target);
    check({name, "_seg"}, seg, exp_seg);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_an", an, 4'b1111);
    check("rst_seg", seg, 7'b1111111);
    check("rst_cnt", {win_cnt, lose_cnt}, 16'h0000);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    check("first_an", an, 4'b1110);
    check("first_seg", seg, 7'b1000000);

    // Level hold: one event, visible one cycle after the rise.
    mw = 1;
    push_cnt();
    win = 1'b1;
    @(posedge clk);
    #1;
    check("hold_latency", win_cnt, 8'h01);
    #1;
    repeat (9) tick();
    win = 1'b0;
    repeat (4) tick();
    check("hold_final", win_cnt, 8'h01);

    // BCD carry on lose
    repeat (10) pulse(1'b0, 1'b1);
    check("carry_lose", lose_cnt, 8'h10);
    wait_an(4'b1101, 7'b1111001, "carry_idx1");
    wait_an(4'b1110, 7'b1000000, "carry_idx0");

    // Wrap or saturate on win
    do_clr();
    repeat (100) pulse(1'b1, 1'b0);
    check("wrap_final", win_cnt, SAT ? 8'h99 : 8'h00);

    // Simultaneous events
    do_clr();
    pulse(1'b1, 1'b1);
    check("simul_cnt", {win_cnt, lose_cnt}, 16'h0101);

    // clr coincident with a new win edge
    mw = 0;
    ml = 0;
    push_cnt();
    win = 1'b1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (5) tick();
    win = 1'b0;
    tick();
    check("clr_edge_cnt", {win_cnt, lose_cnt}, 16'h0000);

    // Scan with 42 / 07
    repeat (7) pulse(1'b1, 1'b1);
    repeat (35) pulse(1'b1, 1'b0);
    check("scan_setup", {win_cnt, lose_cnt}, 16'h4207);
    repeat (4) scan_q.push_back({4'b1110, 7'b1111000});
    repeat (4) scan_q.push_back({4'b1101, 7'b1000000});
    repeat (4) scan_q.push_back({4'b1011, 7'b0100100});
    repeat (4) scan_q.push_back({4'b0111, 7'b0011001});
    scan_en = 1'b1;
    for (int i = 0; i < 200 && !scan_done; i++) @(posedge clk);
    check("scan_done", scan_done, 1);

    // Asynchronous reset between edges
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst_an", an, 4'b1111);
    check("async_rst_seg", seg, 7'b1111111);
    check("async_rst_cnt", {win_cnt, lose_cnt}, 16'h0000);
    mw = 0;
    ml = 0;
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) tick();
    check("pending_counts", cnt_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
